// File: rtl/rs_issue_queue.sv
// rs_issue_queue: ALU reservation station/issue queue, DEPTH entries, NUM_CDB-channel operand wakeup.
// Latency: a dispatched ready op is in the issue register one edge after it is written to an entry.
// Backpressure: registered valid/ready issue port; while iss_valid && !iss_ready every iss_* and entry holds.
//
// Build option: define RS_OLDEST_FIRST_EN for oldest-ready selection via an age matrix;
// otherwise the lowest-index ready entry is selected.
//
// Ports:
//   clk_in, rst_in (sync, active-high), rdy_in (global enable), rollback_in (flush)
//   disp_*           : dispatch request and operands; full/count report occupancy
//   cdb_valid/tag/data : packed result broadcasts, channel k at [k*W +: W]
//   iss_*            : registered issue port to the ALU
module rs_issue_queue #(
  parameter int DEPTH   = 16,
  parameter int TAG_W   = 4,
  parameter int NUM_CDB = 2,
  parameter int OP_W    = 6,
  parameter int XLEN    = 32
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     rdy_in,
  input  logic                     disp_valid,
  input  logic [OP_W-1:0]          disp_op,
  input  logic [XLEN-1:0]          disp_v1,
  input  logic [XLEN-1:0]          disp_v2,
  input  logic [XLEN-1:0]          disp_imm,
  input  logic [XLEN-1:0]          disp_pc,
  input  logic                     disp_q1_pend,
  input  logic                     disp_q2_pend,
  input  logic [TAG_W-1:0]         disp_q1,
  input  logic [TAG_W-1:0]         disp_q2,
  input  logic [TAG_W-1:0]         disp_rob,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  input  logic [NUM_CDB-1:0]       cdb_valid,
  input  logic [NUM_CDB*TAG_W-1:0] cdb_tag,
  input  logic [NUM_CDB*XLEN-1:0]  cdb_data,
  output logic                     iss_valid,
  input  logic                     iss_ready,
  output logic [OP_W-1:0]          iss_op,
  output logic [XLEN-1:0]          iss_v1,
  output logic [XLEN-1:0]          iss_v2,
  output logic [XLEN-1:0]          iss_imm,
  output logic [XLEN-1:0]          iss_pc,
  output logic [TAG_W-1:0]         iss_rob,
  input  logic                     rollback_in
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = IDX_W + 1;

  typedef struct packed {
    logic             busy;
    logic [OP_W-1:0]  op;
    logic [XLEN-1:0]  v1;
    logic [XLEN-1:0]  v2;
    logic [XLEN-1:0]  imm;
    logic [XLEN-1:0]  pc;
    logic [TAG_W-1:0] q1;
    logic [TAG_W-1:0] q2;
    logic             p1;
    logic             p2;
    logic [TAG_W-1:0] rob;
  } entry_t;

  entry_t           ent_q [DEPTH];
  entry_t           ent_d [DEPTH];
  entry_t           disp_ent;

  logic [DEPTH-1:0] busy_vec;
  logic [DEPTH-1:0] ready_vec;
  logic [IDX_W-1:0] free_idx;
  logic [IDX_W-1:0] sel_idx;
  logic             sel_vld;
  logic             disp_acc;
  logic             iss_load;

  // full comes from registered count only, so a slot freed this cycle
  // cannot be reused until the next one.
  assign full     = (count == CNT_W'(DEPTH));
  assign disp_acc = disp_valid && !full;
  assign iss_load = !iss_valid || iss_ready;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      busy_vec[i]  = ent_q[i].busy;
      ready_vec[i] = ent_q[i].busy && !ent_q[i].p1 && !ent_q[i].p2;
    end
  end

  // Lowest-index free slot.
  always_comb begin
    free_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!busy_vec[i]) free_idx = IDX_W'(i);
    end
  end

`ifdef RS_OLDEST_FIRST_EN
  // age_q[i][j] set means entry i was dispatched before entry j. Rows of
  // free entries may hold stale bits; they are masked by ready_vec and
  // cleared when the slot is reallocated.
  logic [DEPTH-1:0] age_q [DEPTH];
  logic [DEPTH-1:0] age_d [DEPTH];
  logic [DEPTH-1:0] older;

  always_comb begin
    sel_vld = 1'b0;
    sel_idx = '0;
    older   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      for (int j = 0; j < DEPTH; j++) older[j] = age_q[j][i];
      if (ready_vec[i] && !sel_vld && ((older & ready_vec) == '0)) begin
        sel_vld = 1'b1;
        sel_idx = IDX_W'(i);
      end
    end
  end

  always_comb begin
    for (int r = 0; r < DEPTH; r++) age_d[r] = age_q[r];
    if (disp_acc) begin
      for (int r = 0; r < DEPTH; r++) begin
        if (busy_vec[r]) age_d[r][free_idx] = 1'b1;
      end
      age_d[free_idx] = '0;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in || rollback_in) begin
      for (int r = 0; r < DEPTH; r++) age_q[r] <= '0;
    end else if (rdy_in) begin
      for (int r = 0; r < DEPTH; r++) age_q[r] <= age_d[r];
    end
  end
`else
  always_comb begin
    sel_vld = 1'b0;
    sel_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (ready_vec[i]) begin
        sel_vld = 1'b1;
        sel_idx = IDX_W'(i);
      end
    end
  end
`endif

  // Dispatch entry with same-cycle bypass. Channels are scanned high to low
  // so the lowest matching channel is the last write and wins.
  always_comb begin
    disp_ent      = '0;
    disp_ent.busy = 1'b1;
    disp_ent.op   = disp_op;
    disp_ent.v1   = disp_v1;
    disp_ent.v2   = disp_v2;
    disp_ent.imm  = disp_imm;
    disp_ent.pc   = disp_pc;
    disp_ent.q1   = disp_q1;
    disp_ent.q2   = disp_q2;
    disp_ent.p1   = disp_q1_pend;
    disp_ent.p2   = disp_q2_pend;
    disp_ent.rob  = disp_rob;
    for (int k = NUM_CDB - 1; k >= 0; k--) begin
      if (cdb_valid[k] && disp_q1_pend && (disp_q1 == cdb_tag[k*TAG_W +: TAG_W])) begin
        disp_ent.p1 = 1'b0;
        disp_ent.v1 = cdb_data[k*XLEN +: XLEN];
      end
      if (cdb_valid[k] && disp_q2_pend && (disp_q2 == cdb_tag[k*TAG_W +: TAG_W])) begin
        disp_ent.p2 = 1'b0;
        disp_ent.v2 = cdb_data[k*XLEN +: XLEN];
      end
    end
  end

  // Next entry state: wakeup, then dispatch write, then issue free. The
  // dispatch slot is never busy and the issued slot always is, so the two
  // writes cannot collide.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ent_d[i] = ent_q[i];
      for (int k = NUM_CDB - 1; k >= 0; k--) begin
        if (cdb_valid[k] && ent_q[i].busy && ent_q[i].p1 &&
            (ent_q[i].q1 == cdb_tag[k*TAG_W +: TAG_W])) begin
          ent_d[i].p1 = 1'b0;
          ent_d[i].v1 = cdb_data[k*XLEN +: XLEN];
        end
        if (cdb_valid[k] && ent_q[i].busy && ent_q[i].p2 &&
            (ent_q[i].q2 == cdb_tag[k*TAG_W +: TAG_W])) begin
          ent_d[i].p2 = 1'b0;
          ent_d[i].v2 = cdb_data[k*XLEN +: XLEN];
        end
      end
    end
    if (disp_acc) ent_d[free_idx] = disp_ent;
    if (iss_load && sel_vld) ent_d[sel_idx].busy = 1'b0;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
      count     <= '0;
      iss_valid <= 1'b0;
      iss_op    <= '0;
      iss_v1    <= '0;
      iss_v2    <= '0;
      iss_imm   <= '0;
      iss_pc    <= '0;
      iss_rob   <= '0;
    end else if (rollback_in) begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i].busy <= 1'b0;
        ent_q[i].p1   <= 1'b0;
        ent_q[i].p2   <= 1'b0;
      end
      count     <= '0;
      iss_valid <= 1'b0;
    end else if (rdy_in) begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
      count <= count + CNT_W'(disp_acc) - CNT_W'(iss_load && sel_vld);
      if (iss_load) begin
        iss_valid <= sel_vld;
        if (sel_vld) begin
          iss_op  <= ent_q[sel_idx].op;
          iss_v1  <= ent_q[sel_idx].v1;
          iss_v2  <= ent_q[sel_idx].v2;
          iss_imm <= ent_q[sel_idx].imm;
          iss_pc  <= ent_q[sel_idx].pc;
          iss_rob <= ent_q[sel_idx].rob;
        end
      end
    end
  end

endmodule

// File: tb/tb_rs_issue_queue.sv
// tb_rs_issue_queue: directed scenarios for rs_issue_queue (DEPTH=16, NUM_CDB=2).
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.
// Expected selection order follows whether RS_OLDEST_FIRST_EN is defined.
module tb_rs_issue_queue;
  localparam int DEPTH   = 16;
  localparam int TAG_W   = 4;
  localparam int NUM_CDB = 2;
  localparam int OP_W    = 6;
  localparam int XLEN    = 32;

  logic                     clk_in = 1'b0;
  logic                     rst_in;
  logic                     rdy_in;
  logic                     disp_valid;
  logic [OP_W-1:0]          disp_op;
  logic [XLEN-1:0]          disp_v1;
  logic [XLEN-1:0]          disp_v2;
  logic [XLEN-1:0]          disp_imm;
  logic [XLEN-1:0]          disp_pc;
  logic                     disp_q1_pend;
  logic                     disp_q2_pend;
  logic [TAG_W-1:0]         disp_q1;
  logic [TAG_W-1:0]         disp_q2;
  logic [TAG_W-1:0]         disp_rob;
  logic                     full;
  logic [4:0]               count;
  logic [NUM_CDB-1:0]       cdb_valid;
  logic [NUM_CDB*TAG_W-1:0] cdb_tag;
  logic [NUM_CDB*XLEN-1:0]  cdb_data;
  logic                     iss_valid;
  logic                     iss_ready;
  logic [OP_W-1:0]          iss_op;
  logic [XLEN-1:0]          iss_v1;
  logic [XLEN-1:0]          iss_v2;
  logic [XLEN-1:0]          iss_imm;
  logic [XLEN-1:0]          iss_pc;
  logic [TAG_W-1:0]         iss_rob;
  logic                     rollback_in;

  int total = 0;
  int bad   = 0;

  always #5 clk_in = ~clk_in;

  rs_issue_queue #(
    .DEPTH(DEPTH), .TAG_W(TAG_W), .NUM_CDB(NUM_CDB), .OP_W(OP_W), .XLEN(XLEN)
  ) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .disp_valid(disp_valid), .disp_op(disp_op), .disp_v1(disp_v1), .disp_v2(disp_v2),
    .disp_imm(disp_imm), .disp_pc(disp_pc), .disp_q1_pend(disp_q1_pend),
    .disp_q2_pend(disp_q2_pend), .disp_q1(disp_q1), .disp_q2(disp_q2), .disp_rob(disp_rob),
    .full(full), .count(count),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_op(iss_op), .iss_v1(iss_v1),
    .iss_v2(iss_v2), .iss_imm(iss_imm), .iss_pc(iss_pc), .iss_rob(iss_rob),
    .rollback_in(rollback_in)
  );

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle();
    disp_valid   = 1'b0;
    disp_q1_pend = 1'b0;
    disp_q2_pend = 1'b0;
    cdb_valid    = '0;
    rollback_in  = 1'b0;
  endtask

  task automatic set_disp(input logic [XLEN-1:0] v1, input logic [XLEN-1:0] v2,
                          input logic p1, input logic [TAG_W-1:0] q1,
                          input logic p2, input logic [TAG_W-1:0] q2,
                          input logic [TAG_W-1:0] rob);
    disp_valid   = 1'b1;
    disp_op      = 6'd1;
    disp_v1      = v1;
    disp_v2      = v2;
    disp_imm     = 32'h0000_0010;
    disp_pc      = 32'h0000_1000;
    disp_q1_pend = p1;
    disp_q1      = q1;
    disp_q2_pend = p2;
    disp_q2      = q2;
    disp_rob     = rob;
  endtask

  task automatic test_reset();
    rst_in = 1'b1;
    tick();
    tick();
    rst_in = 1'b0;
    total++; if (iss_valid !== 1'b0) begin bad++; $display("FAIL reset_iss_valid got=%b want=0", iss_valid); end
    total++; if (count !== 5'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", count); end
    total++; if (full !== 1'b0) begin bad++; $display("FAIL reset_full got=%b want=0", full); end
    total++; if (iss_v1 !== 32'd0 || iss_rob !== 4'd0) begin bad++; $display("FAIL reset_iss_data got v1=%0h rob=%0h want 0", iss_v1, iss_rob); end
  endtask

  task automatic test_basic();
    iss_ready = 1'b1;
    set_disp(32'd5, 32'd7, 1'b0, 4'd0, 1'b0, 4'd0, 4'd3);
    tick();
    idle();
    total++; if (count !== 5'd1 || iss_valid !== 1'b0) begin bad++; $display("FAIL basic_written got count=%0d valid=%b want 1/0", count, iss_valid); end
    tick();
    total++; if (iss_valid !== 1'b1) begin bad++; $display("FAIL basic_valid got=%b want=1", iss_valid); end
    total++; if (iss_v1 !== 32'd5 || iss_v2 !== 32'd7) begin bad++; $display("FAIL basic_operands got=%0d,%0d want=5,7", iss_v1, iss_v2); end
    total++; if (iss_op !== 6'd1 || iss_rob !== 4'd3 || iss_imm !== 32'h10 || iss_pc !== 32'h1000) begin bad++; $display("FAIL basic_fields got op=%0d rob=%0d imm=%0h pc=%0h want 1/3/10/1000", iss_op, iss_rob, iss_imm, iss_pc); end
    total++; if (count !== 5'd0) begin bad++; $display("FAIL basic_count got=%0d want=0", count); end
    tick();
    total++; if (iss_valid !== 1'b0) begin bad++; $display("FAIL basic_drain got=%b want=0", iss_valid); end
  endtask

  task automatic test_wakeup();
    set_disp(32'd0, 32'd9, 1'b1, 4'd3, 1'b0, 4'd0, 4'd2);
    tick();
    idle();
    tick();
    total++; if (iss_valid !== 1'b0) begin bad++; $display("FAIL wake_waiting got=%b want=0", iss_valid); end
    cdb_valid = 2'b10;
    cdb_tag   = {4'd3, 4'd0};
    cdb_data  = {32'hDEAD, 32'h0};
    tick();
    idle();
    total++; if (iss_valid !== 1'b0) begin bad++; $display("FAIL wake_edge got=%b want=0", iss_valid); end
    tick();
    total++; if (iss_valid !== 1'b1 || iss_v1 !== 32'hDEAD || iss_v2 !== 32'd9) begin bad++; $display("FAIL wake_issue got valid=%b v1=%0h v2=%0d want 1/dead/9", iss_valid, iss_v1, iss_v2); end
    tick();
  endtask

  task automatic test_cdb_priority();
    set_disp(32'd0, 32'd0, 1'b1, 4'd5, 1'b1, 4'd5, 4'd4);
    tick();
    idle();
    cdb_valid = 2'b11;
    cdb_tag   = {4'd5, 4'd5};
    cdb_data  = {32'h22, 32'h11};
    tick();
    idle();
    tick();
    total++; if (iss_valid !== 1'b1 || iss_v1 !== 32'h11 || iss_v2 !== 32'h11) begin bad++; $display("FAIL cdb_lowest_wins got valid=%b v1=%0h v2=%0h want 1/11/11", iss_valid, iss_v1, iss_v2); end
    tick();
  endtask

  task automatic test_bypass();
    set_disp(32'd1, 32'd0, 1'b0, 4'd0, 1'b1, 4'd6, 4'd5);
    cdb_valid = 2'b01;
    cdb_tag   = {4'd0, 4'd6};
    cdb_data  = {32'h0, 32'd42};
    tick();
    idle();
    total++; if (count !== 5'd1) begin bad++; $display("FAIL bypass_count got=%0d want=1", count); end
    tick();
    total++; if (iss_valid !== 1'b1 || iss_v2 !== 32'd42 || iss_v1 !== 32'd1) begin bad++; $display("FAIL bypass_issue got valid=%b v1=%0d v2=%0d want 1/1/42", iss_valid, iss_v1, iss_v2); end
    tick();
  endtask

  task automatic test_back_to_back();
    iss_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_disp(32'(10 + i), 32'd0, 1'b0, 4'd0, 1'b0, 4'd0, 4'd0);
      tick();
      if (i > 0) begin
        total++; if (iss_valid !== 1'b1 || iss_v1 !== 32'(9 + i)) begin bad++; $display("FAIL b2b_issue got valid=%b v1=%0d want 1/%0d", iss_valid, iss_v1, 9 + i); end
      end
    end
    idle();
    tick();
    total++; if (iss_v1 !== 32'd13 || count !== 5'd0) begin bad++; $display("FAIL b2b_last got v1=%0d count=%0d want 13/0", iss_v1, count); end
    // Frozen: dispatch ignored, issue register held despite iss_ready.
    rdy_in = 1'b0;
    set_disp(32'h99, 32'd0, 1'b0, 4'd0, 1'b0, 4'd0, 4'd0);
    tick();
    tick();
    total++; if (iss_valid !== 1'b1 || iss_v1 !== 32'd13 || count !== 5'd0) begin bad++; $display("FAIL freeze_hold got valid=%b v1=%0d count=%0d want 1/13/0", iss_valid, iss_v1, count); end
    idle();
    rdy_in = 1'b1;
    tick();
    total++; if (iss_valid !== 1'b0) begin bad++; $display("FAIL freeze_release got=%b want=0", iss_valid); end
  endtask

  task automatic test_full();
    logic [XLEN-1:0] first_exp;
`ifdef RS_OLDEST_FIRST_EN
    first_exp = 32'd101;
`else
    first_exp = 32'd102;
`endif
    iss_ready = 1'b0;
    // 17 dispatches: one ends up in the issue register, 16 fill the entries.
    for (int i = 0; i < 17; i++) begin
      set_disp(32'(100 + i), 32'd0, 1'b0, 4'd0, 1'b0, 4'd0, 4'(i));
      tick();
    end
    idle();
    total++; if (count !== 5'd16 || full !== 1'b1) begin bad++; $display("FAIL full_state got count=%0d full=%b want 16/1", count, full); end
    set_disp(32'd999, 32'd0, 1'b0, 4'd0, 1'b0, 4'd0, 4'd0);
    tick();
    idle();
    total++; if (count !== 5'd16) begin bad++; $display("FAIL full_drop got count=%0d want=16", count); end
    for (int c = 0; c < 10; c++) begin
      tick();
      total++; if (iss_valid !== 1'b1 || iss_v1 !== 32'd100 || count !== 5'd16) begin bad++; $display("FAIL stall_stable cyc=%0d got valid=%b v1=%0d count=%0d want 1/100/16", c, iss_valid, iss_v1, count); end
    end
    iss_ready = 1'b1;
    tick();
    total++; if (iss_v1 !== first_exp || count !== 5'd15 || full !== 1'b0) begin bad++; $display("FAIL drain_first got v1=%0d count=%0d full=%b want %0d/15/0", iss_v1, count, full, first_exp); end
    for (int n = 14; n >= 0; n--) begin
      tick();
      total++; if (iss_valid !== 1'b1 || count !== 5'(n)) begin bad++; $display("FAIL drain_rate got valid=%b count=%0d want 1/%0d", iss_valid, count, n); end
    end
    tick();
    total++; if (iss_valid !== 1'b0) begin bad++; $display("FAIL drain_empty got=%b want=0", iss_valid); end
  endtask

  task automatic test_age();
    logic [XLEN-1:0] first_exp;
    logic [XLEN-1:0] second_exp;
`ifdef RS_OLDEST_FIRST_EN
    first_exp  = 32'hA1;
    second_exp = 32'hB1;
`else
    first_exp  = 32'hB1;
    second_exp = 32'hA1;
`endif
    iss_ready = 1'b0;
    set_disp(32'h55, 32'd0, 1'b0, 4'd0, 1'b0, 4'd0, 4'd0);
    tick();
    idle();
    tick();
    total++; if (iss_valid !== 1'b1 || iss_v1 !== 32'h55) begin bad++; $display("FAIL age_park got valid=%b v1=%0h want 1/55", iss_valid, iss_v1); end
    // Slots 0,1,3,4: fillers waiting on tag 15; slot 2: ready X; slot 5: A waiting on tag 9.
    set_disp(32'h0, 32'd0, 1'b1, 4'd15, 1'b0, 4'd0, 4'd0); tick();
    set_disp(32'h0, 32'd0, 1'b1, 4'd15, 1'b0, 4'd0, 4'd0); tick();
    set_disp(32'h77, 32'd0, 1'b0, 4'd0, 1'b0, 4'd0, 4'd0); tick();
    set_disp(32'h0, 32'd0, 1'b1, 4'd15, 1'b0, 4'd0, 4'd0); tick();
    set_disp(32'h0, 32'd0, 1'b1, 4'd15, 1'b0, 4'd0, 4'd0); tick();
    set_disp(32'h0, 32'hA0, 1'b1, 4'd9, 1'b0, 4'd0, 4'd0); tick();
    idle();
    iss_ready = 1'b1;
    tick();
    iss_ready = 1'b0;
    total++; if (iss_v1 !== 32'h77 || count !== 5'd5) begin bad++; $display("FAIL age_free_slot got v1=%0h count=%0d want 77/5", iss_v1, count); end
    set_disp(32'h0, 32'hB0, 1'b1, 4'd10, 1'b0, 4'd0, 4'd0);
    tick();
    idle();
    cdb_valid = 2'b11;
    cdb_tag   = {4'd10, 4'd9};
    cdb_data  = {32'hB1, 32'hA1};
    iss_ready = 1'b1;
    tick();
    idle();
    total++; if (iss_valid !== 1'b0) begin bad++; $display("FAIL age_wake_edge got=%b want=0", iss_valid); end
    tick();
    total++; if (iss_valid !== 1'b1 || iss_v1 !== first_exp) begin bad++; $display("FAIL age_first got valid=%b v1=%0h want 1/%0h", iss_valid, iss_v1, first_exp); end
    tick();
    total++; if (iss_valid !== 1'b1 || iss_v1 !== second_exp) begin bad++; $display("FAIL age_second got valid=%b v1=%0h want 1/%0h", iss_valid, iss_v1, second_exp); end
    tick();
    total++; if (iss_valid !== 1'b0 || count !== 5'd4) begin bad++; $display("FAIL age_leftover got valid=%b count=%0d want 0/4", iss_valid, count); end
  endtask

  task automatic test_rollback();
    rollback_in = 1'b1;
    tick();
    idle();
    total++; if (count !== 5'd0) begin bad++; $display("FAIL rb_clear got count=%0d want=0", count); end
    iss_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      set_disp(32'(i), 32'd0, 1'b0, 4'd0, 1'b0, 4'd0, 4'd0);
      tick();
    end
    idle();
    total++; if (count !== 5'd8 || iss_valid !== 1'b1 || iss_v1 !== 32'd0) begin bad++; $display("FAIL rb_fill got count=%0d valid=%b v1=%0d want 8/1/0", count, iss_valid, iss_v1); end
    rollback_in = 1'b1;
    set_disp(32'h5A, 32'd0, 1'b0, 4'd0, 1'b0, 4'd0, 4'd0);
    cdb_valid = 2'b11;
    cdb_tag   = {4'd1, 4'd2};
    cdb_data  = {32'h1, 32'h2};
    tick();
    idle();
    total++; if (count !== 5'd0 || iss_valid !== 1'b0 || full !== 1'b0) begin bad++; $display("FAIL rb_flush got count=%0d valid=%b full=%b want 0/0/0", count, iss_valid, full); end
    iss_ready = 1'b1;
    tick();
    tick();
    total++; if (count !== 5'd0 || iss_valid !== 1'b0) begin bad++; $display("FAIL rb_ignored_disp got count=%0d valid=%b want 0/0", count, iss_valid); end
  endtask

  initial begin
    rst_in    = 1'b0;
    rdy_in    = 1'b1;
    iss_ready = 1'b0;
    disp_op   = '0;
    disp_v1   = '0;
    disp_v2   = '0;
    disp_imm  = '0;
    disp_pc   = '0;
    disp_q1   = '0;
    disp_q2   = '0;
    disp_rob  = '0;
    cdb_tag   = '0;
    cdb_data  = '0;
    idle();
    test_reset();
    test_basic();
    test_wakeup();
    test_cdb_priority();
    test_bypass();
    test_back_to_back();
    test_full();
    test_age();
    test_rollback();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/rs_issue_queue.md
# rs_issue_queue

Parametrised successor to the ALU reservation station; sits between the dispatcher and the ALU.
- Holds up to DEPTH in-flight ALU operations.
- Captures operands from NUM_CDB result broadcast channels, including same-cycle bypass at dispatch.
- Issues one ready operation per cycle through a registered valid/ready port, so a stalled ALU never loses an instruction.
- Flushes completely on ROB rollback.

## Interface
Parameters:
- DEPTH, 16: entry count, power of two, 2..32.
- TAG_W, 4: ROB tag width.
- NUM_CDB, 2: broadcast channel count, 1..4; channel 0 = ALU, 1 = LSU.
- OP_W, 6: op enum width.
- XLEN, 32: data and address width.

Ports:
- clk_in, input, 1: clock.
- rst_in, input, 1: reset; one clock, synchronous, active-high.
- rdy_in, input, 1: global enable; low freezes all state.
- disp_valid, input, 1: dispatch request.
- disp_op, input, OP_W: op enum.
- disp_v1, input, XLEN: operand 1 value.
- disp_v2, input, XLEN: operand 2 value.
- disp_imm, input, XLEN: immediate.
- disp_pc, input, XLEN: instruction address.
- disp_q1_pend, input, 1: operand 1 waiting on disp_q1.
- disp_q2_pend, input, 1: operand 2 waiting on disp_q2.
- disp_q1, input, TAG_W: producer tag for operand 1.
- disp_q2, input, TAG_W: producer tag for operand 2.
- disp_rob, input, TAG_W: destination ROB tag.
- full, output, 1: no free entry.
- count, output, log2(DEPTH)+1: occupied entries.
- cdb_valid, input, NUM_CDB: per-channel broadcast valid.
- cdb_tag, input, NUM_CDB*TAG_W: packed tags; channel k at [k*TAG_W +: TAG_W].
- cdb_data, input, NUM_CDB*XLEN: packed results.
- iss_valid, output, 1: issue register holds an op.
- iss_ready, input, 1: ALU accepts (replaces the old busy input).
- iss_op, output, OP_W: issued op enum.
- iss_v1, iss_v2, iss_imm, iss_pc, output, XLEN each: issued operands, immediate, address.
- iss_rob, output, TAG_W: issued ROB tag.
- rollback_in, input, 1: flush.

## Operation
- Entry fields: busy, op, v1, v2, imm, pc, q1/q2 tag, q1/q2 pend, rob.
- **Dispatch:** accepted when disp_valid && !full. Writes the lowest-index free entry.
- **Dispatch bypass:** if a pend operand's tag matches a valid CDB channel in the same cycle, the entry is written with pend=0 and that channel's data.
- **Wakeup:** every busy entry with pend=1 and a tag equal to a valid channel captures the data and clears pend.
  - Both operands are checked independently on every channel.
  - If several channels carry the same tag, the lowest channel index wins.
- **Ready:** entry is ready when busy && !q1_pend && !q2_pend.
- **Selection:** one ready entry per cycle, chosen per the Configuration section.
- **Issue register load:** loads the selected entry and frees it when !iss_valid || iss_ready. Otherwise the register and all entries hold.
- **Issue register drain:** if iss_valid && iss_ready with no ready entry, iss_valid clears.
- **count:** +1 on dispatch accept, -1 on issue load; both in one cycle leaves it unchanged.
- **full:** count==DEPTH, registered state only; a slot freed this cycle is usable next cycle.
- **Priority:** rst_in > rollback_in > rdy_in low > normal.
  - rollback_in: all busy=0, iss_valid=0, count=0 at the edge. Dispatch and CDB in that cycle are ignored.
- **Reset values:** iss_valid=0; iss_op, iss_v1, iss_v2, iss_imm, iss_pc, iss_rob = 0; count=0; full=0; all entries busy=0, pend=0.
- **rdy_in low:** no state change; outputs hold; dispatch ignored.

## Timing
- Dispatch at edge k with both operands available: iss_valid at edge k+1 at the earliest (entry selected in cycle k+1, visible after edge k+2 if the issue register is busy).
- Precisely: entry written at edge k is selectable during cycle k→k+1 and is in the issue register after edge k+1.
- CDB wakeup at edge k: entry selectable in the following cycle; issued after edge k+1.
- Bypassed dispatch has the same latency as a non-pending dispatch.
- Backpressure: while iss_valid && !iss_ready, all iss_* outputs are stable.
- Throughput: one issue per cycle with iss_ready held high.

## Configuration
- RS_OLDEST_FIRST_EN defined:
  - A DEPTH×DEPTH age matrix records dispatch order; the oldest ready entry is selected.
  - On dispatch, the new entry's row is cleared and its column is set in all busy rows.
  - Rollback and reset clear the matrix.
- RS_OLDEST_FIRST_EN undefined: the lowest-index ready entry is selected; no age matrix is built.

## Test plan
- Reset, then dispatch op=ADD, v1=5, v2=7, no pend, iss_ready=1 → iss_valid=1 next edge with iss_v1=5, iss_v2=7; count returns to 0.
- Dispatch q1_pend, q1=3; two cycles later cdb_valid[1]=1, tag=3, data=0xDEAD → iss_v1=0xDEAD one edge after the broadcast.
- Dispatch q2=6 in the same cycle as cdb_valid[0], tag=6, data=42 → entry never waits; iss_v2=42 on the next edge.
- Fill 16 entries with iss_ready=0 → full=1; a 17th dispatch is dropped; iss_* stable for 10 cycles; releasing iss_ready drains one per cycle.
- With RS_OLDEST_FIRST_EN: dispatch A into entry 5, then B into entry 2; wake B then A in the same cycle → A issues first. Without the macro, B issues first.
- Fill 8 entries with iss_valid=1, then assert rollback_in with a simultaneous dispatch and CDB → next edge count=0, iss_valid=0, full=0.
